// File: rtl/fpu_noncomp_pkg.sv
// fpu_noncomp_pkg
// Shared definitions for the non-computational RV32F responder: opcode and
// sub-op encodings, the fflags bit order, the canonical quiet NaN, the
// per-operand classification struct and the helpers that fill it.
package fpu_noncomp_pkg;

  localparam logic [2:0] NCP_SGNJ   = 3'd0;
  localparam logic [2:0] NCP_MINMAX = 3'd1;
  localparam logic [2:0] NCP_CMP    = 3'd2;
  localparam logic [2:0] NCP_CLASS  = 3'd3;
  localparam logic [2:0] NCP_MV     = 3'd4;

  localparam logic [2:0] FRM_SGNJ  = 3'd0;
  localparam logic [2:0] FRM_SGNJN = 3'd1;
  localparam logic [2:0] FRM_SGNJX = 3'd2;
  localparam logic [2:0] FRM_MIN   = 3'd0;
  localparam logic [2:0] FRM_MAX   = 3'd1;
  localparam logic [2:0] FRM_FLE   = 3'd0;
  localparam logic [2:0] FRM_FLT   = 3'd1;
  localparam logic [2:0] FRM_FEQ   = 3'd2;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_sub;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    logic expZero;
    logic expOnes;
    logic manZero;
    expZero   = (x[30:23] == 8'h00);
    expOnes   = (x[30:23] == 8'hFF);
    manZero   = (x[22:0] == 23'd0);
    c.sign    = x[31];
    c.is_zero = expZero && manZero;
    c.is_sub  = expZero && !manZero;
    c.is_inf  = expOnes && manZero;
    c.is_nan  = expOnes && !manZero;
    // A NaN is signalling when the quiet bit (top mantissa bit) is clear.
    c.is_snan = expOnes && !manZero && !x[22];
    return c;
  endfunction

  // Only min/max and compares report exception flags.
  function automatic logic op_has_flags(input logic [2:0] op, input logic [2:0] frm);
    logic hasFlags;
    case (op)
      NCP_MINMAX: hasFlags = (frm == FRM_MIN) || (frm == FRM_MAX);
      NCP_CMP:    hasFlags = (frm == FRM_FLE) || (frm == FRM_FLT) || (frm == FRM_FEQ);
      default:    hasFlags = 1'b0;
    endcase
    return hasFlags;
  endfunction

endpackage

// File: rtl/fpu_noncomp_lane.sv
// fpu_noncomp_lane
// One 32-bit lane of the non-computational FPU pipeline. Stage 0 registers
// the operands together with their classification; stage 1 produces the
// result word and the NV flag. Both stages advance only while en_i is high.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   en_i         pipeline advance enable (low while the output is stalled)
//   a_i, b_i     raw operands of the incoming request
//   op_i, frm_i  opcode / sub-op already registered in stage 0 by the top
//   result_o     registered lane result
//   nv_o         registered invalid-operation flag
module fpu_noncomp_lane
  import fpu_noncomp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic [2:0]  frm_i,
  output logic [31:0] result_o,
  output logic        nv_o
);

  logic [31:0] a_q, b_q;
  fp_class_t   aClass_q, bClass_q;
  logic [31:0] result_q, result_d;
  logic        nv_q, nv_d;

  logic        bothZero, anyNan, anySnan, ltTotal, eqVal, aNorm;
  logic [9:0]  classBits;

  // Stage 0: capture operands and precompute their classes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      aClass_q <= '0;
      bClass_q <= '0;
    end else if (en_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      aClass_q <= classify(a_i);
      bClass_q <= classify(b_i);
    end
  end

  assign bothZero = aClass_q.is_zero && bClass_q.is_zero;
  assign anyNan   = aClass_q.is_nan || bClass_q.is_nan;
  assign anySnan  = aClass_q.is_snan || bClass_q.is_snan;

  // Sign-magnitude total order where -0 sorts below +0; NaNs are handled
  // separately by every user of this signal.
  assign ltTotal = (aClass_q.sign != bClass_q.sign) ? aClass_q.sign :
                   (aClass_q.sign ? (a_q[30:0] > b_q[30:0]) : (a_q[30:0] < b_q[30:0]));
  assign eqVal   = (a_q == b_q) || bothZero;

  assign aNorm = !(aClass_q.is_zero || aClass_q.is_sub || aClass_q.is_inf || aClass_q.is_nan);
  assign classBits = {
    aClass_q.is_nan && !aClass_q.is_snan,
    aClass_q.is_snan,
    !aClass_q.sign && aClass_q.is_inf,
    !aClass_q.sign && aNorm,
    !aClass_q.sign && aClass_q.is_sub,
    !aClass_q.sign && aClass_q.is_zero,
    aClass_q.sign && aClass_q.is_zero,
    aClass_q.sign && aClass_q.is_sub,
    aClass_q.sign && aNorm,
    aClass_q.sign && aClass_q.is_inf
  };

  // Stage 1 result selection; unknown op or sub-op yields zero with no flags.
  always_comb begin
    result_d = '0;
    nv_d     = 1'b0;
    case (op_i)
      NCP_SGNJ: begin
        case (frm_i)
          FRM_SGNJ:  result_d = {b_q[31], a_q[30:0]};
          FRM_SGNJN: result_d = {~b_q[31], a_q[30:0]};
          FRM_SGNJX: result_d = {a_q[31] ^ b_q[31], a_q[30:0]};
          default:   result_d = '0;
        endcase
      end
      NCP_MINMAX: begin
        if ((frm_i == FRM_MIN) || (frm_i == FRM_MAX)) begin
          nv_d = anySnan;
          if (aClass_q.is_nan && bClass_q.is_nan) begin
            result_d = FP_QNAN;
          end else if (aClass_q.is_nan) begin
            result_d = b_q;
          end else if (bClass_q.is_nan) begin
            result_d = a_q;
          end else if (frm_i == FRM_MIN) begin
            result_d = ltTotal ? a_q : b_q;
          end else begin
            result_d = ltTotal ? b_q : a_q;
          end
        end
      end
      NCP_CMP: begin
        case (frm_i)
          FRM_FEQ: begin
            nv_d     = anySnan;
            result_d = {31'd0, !anyNan && eqVal};
          end
          FRM_FLT: begin
            nv_d     = anyNan;
            result_d = {31'd0, !anyNan && ltTotal && !bothZero};
          end
          FRM_FLE: begin
            nv_d     = anyNan;
            result_d = {31'd0, !anyNan && ((ltTotal && !bothZero) || eqVal)};
          end
          default: result_d = '0;
        endcase
      end
      NCP_CLASS: result_d = {22'd0, classBits};
      NCP_MV:    result_d = a_q;
      default:   result_d = '0;
    endcase
  end

  // Stage 1: output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      nv_q     <= 1'b0;
    end else if (en_i) begin
      result_q <= result_d;
      nv_q     <= nv_d;
    end
  end

  assign result_o = result_q;
  assign nv_o     = nv_q;

endmodule

// File: rtl/fpu_noncomp.sv
// fpu_noncomp
// Tagged two-stage responder for the RV32F sign-injection, min/max, compare,
// classify and move operations, one lane per thread. The whole pipeline
// stalls while a response is presented and not taken.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   valid_in/ready_in     request handshake (ready_in is combinational)
//   tag_in, op_type, frm  request tag, NCP_* opcode, sub-op
//   dataa, datab          NUM_LANES x 32-bit operands
//   result, fflags        NUM_LANES x 32-bit results, NUM_LANES x {NV,DZ,OF,UF,NX}
//   has_fflags, tag_out   response flag-valid indication and tag
//   valid_out/ready_out   response handshake
module fpu_noncomp
  import fpu_noncomp_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAGW      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [TAGW-1:0]         tag_in,
  input  logic [2:0]              op_type,
  input  logic [2:0]              frm,
  input  logic [NUM_LANES*32-1:0] dataa,
  input  logic [NUM_LANES*32-1:0] datab,
  output logic [NUM_LANES*32-1:0] result,
  output logic                    has_fflags,
  output logic [NUM_LANES*5-1:0]  fflags,
  output logic [TAGW-1:0]         tag_out,
  output logic                    valid_out,
  input  logic                    ready_out
);

  logic            stall, en;
  logic            valid0_q;
  logic [TAGW-1:0] tag0_q;
  logic [2:0]      op0_q, frm0_q;
  logic            valid1_q;
  logic [TAGW-1:0] tag1_q;
  logic            hasFlags1_q;
  logic [NUM_LANES-1:0] laneNv;

  // Empty stages are not collapsed: any stall freezes every stage.
  assign stall    = valid1_q && !ready_out;
  assign en       = !stall;
  assign ready_in = en;

  // Stage 0 control: valid, tag and decoded request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid0_q <= 1'b0;
      tag0_q   <= '0;
      op0_q    <= '0;
      frm0_q   <= '0;
    end else if (en) begin
      valid0_q <= valid_in;
      tag0_q   <= tag_in;
      op0_q    <= op_type;
      frm0_q   <= frm;
    end
  end

  // Stage 1 control: response valid, tag and flag-valid indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q    <= 1'b0;
      tag1_q      <= '0;
      hasFlags1_q <= 1'b0;
    end else if (en) begin
      valid1_q    <= valid0_q;
      tag1_q      <= tag0_q;
      hasFlags1_q <= op_has_flags(op0_q, frm0_q);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    fflags_t laneFlags;

    fpu_noncomp_lane uLane (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en),
      .a_i      (dataa[32*i +: 32]),
      .b_i      (datab[32*i +: 32]),
      .op_i     (op0_q),
      .frm_i    (frm0_q),
      .result_o (result[32*i +: 32]),
      .nv_o     (laneNv[i])
    );

    // Only the invalid-operation flag can ever be raised by these ops.
    assign laneFlags = '{nv: laneNv[i], dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};
    assign fflags[5*i +: 5] = laneFlags;
  end

  assign valid_out  = valid1_q;
  assign tag_out    = tag1_q;
  assign has_fflags = hasFlags1_q;

endmodule
